// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and constants for the debug dump sequencer
package debug_pkg;

    localparam int FRAME_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_GAP
    } state_t;

    // Snapshot of the halted CPU and bus, frozen for the whole frame
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] last_pc;
        logic [7:0]  opcode;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rd;
        logic        wr;
        logic        cs;
    } snap_t;

    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_L    = 8'h4C;
    localparam logic [7:0] CH_O    = 8'h4F;
    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_C    = 8'h43;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

endpackage

// File: rtl/debug_dump_seq_if.sv
// rtl/debug_dump_seq_if.sv - byte handshake between the sequencer and uart_tx
interface debug_dump_seq_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy
    );

endinterface

// File: rtl/hex_ascii.sv
// rtl/hex_ascii.sv - nibble to uppercase ASCII hex digit
module hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // '0'-'9' sit at 0x30, 'A'-'F' start at 0x41 (0x37 + 10)
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'd0, nibble};
        end else begin
            ascii = 8'h37 + {4'd0, nibble};
        end
    end

endmodule

// File: rtl/debug_dump_seq.sv
// rtl/debug_dump_seq.sv - halt snapshot to 32-byte ASCII line over uart_tx
module debug_dump_seq
    import debug_pkg::*;
#(
    parameter int REPEAT     = 0,
    parameter int GAP_CYCLES = 16,
    parameter int BUSY_TO    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    halt,
    input  logic [15:0]             addr,
    input  logic [7:0]              data,
    input  logic                    rd,
    input  logic                    wr,
    input  logic                    cs,
    input  logic [7:0]              opcode,
    input  logic [15:0]             pc,
    input  logic [15:0]             last_pc,
    debug_dump_seq_if.master        tx,
    output logic                    active,
    output logic [7:0]              frame_count
);

    localparam int TW = $clog2(BUSY_TO + 1);

    state_t        state_q, state_d;
    logic [2:0]    sync_q, sync_d;      // [0],[1] synchroniser, [2] previous synced value
    logic [4:0]    idx_q, idx_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          active_q, active_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    gap_q, gap_d;
    snap_t         snap_q, snap_d;

    logic          trigger;
    logic [3:0]    nibble;
    logic          use_hex;
    logic [7:0]    lit_char;
    logic [7:0]    hex_char;
    logic [7:0]    frame_byte;

    assign trigger      = sync_q[1] & ~sync_q[2];
    assign tx.tx_data   = tx_data_q;
    assign tx.tx_start  = (state_q == ST_START);
    assign active       = active_q;
    assign frame_count  = frame_count_q;

    hex_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    // Select the literal character or snapshot nibble for the current byte index
    always_comb begin
        nibble   = 4'h0;
        use_hex  = 1'b0;
        lit_char = CH_SP;
        case (idx_q)
            5'd0:  lit_char = CH_P;
            5'd1:  begin use_hex = 1'b1; nibble = snap_q.pc[15:12];      end
            5'd2:  begin use_hex = 1'b1; nibble = snap_q.pc[11:8];       end
            5'd3:  begin use_hex = 1'b1; nibble = snap_q.pc[7:4];        end
            5'd4:  begin use_hex = 1'b1; nibble = snap_q.pc[3:0];        end
            5'd6:  lit_char = CH_L;
            5'd7:  begin use_hex = 1'b1; nibble = snap_q.last_pc[15:12]; end
            5'd8:  begin use_hex = 1'b1; nibble = snap_q.last_pc[11:8];  end
            5'd9:  begin use_hex = 1'b1; nibble = snap_q.last_pc[7:4];   end
            5'd10: begin use_hex = 1'b1; nibble = snap_q.last_pc[3:0];   end
            5'd12: lit_char = CH_O;
            5'd13: begin use_hex = 1'b1; nibble = snap_q.opcode[7:4];    end
            5'd14: begin use_hex = 1'b1; nibble = snap_q.opcode[3:0];    end
            5'd16: lit_char = CH_A;
            5'd17: begin use_hex = 1'b1; nibble = snap_q.addr[15:12];    end
            5'd18: begin use_hex = 1'b1; nibble = snap_q.addr[11:8];     end
            5'd19: begin use_hex = 1'b1; nibble = snap_q.addr[7:4];      end
            5'd20: begin use_hex = 1'b1; nibble = snap_q.addr[3:0];      end
            5'd22: lit_char = CH_D;
            5'd23: begin use_hex = 1'b1; nibble = snap_q.data[7:4];      end
            5'd24: begin use_hex = 1'b1; nibble = snap_q.data[3:0];      end
            5'd26: lit_char = CH_F;
            5'd27: lit_char = snap_q.rd ? CH_R : CH_DASH;
            5'd28: lit_char = snap_q.wr ? CH_W : CH_DASH;
            5'd29: lit_char = snap_q.cs ? CH_C : CH_DASH;
            5'd30: lit_char = CH_CR;
            5'd31: lit_char = CH_LF;
            default: lit_char = CH_SP;
        endcase
        frame_byte = use_hex ? hex_char : lit_char;
    end

    // Next-state and datapath: one byte per LOAD/START/WAIT round, trigger only armed in IDLE
    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[1], sync_q[0], halt};
        idx_d         = idx_q;
        tx_data_d     = tx_data_q;
        active_d      = active_q;
        frame_count_d = frame_count_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        snap_d        = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                snap_d.pc      = pc;
                snap_d.last_pc = last_pc;
                snap_d.opcode  = opcode;
                snap_d.addr    = addr;
                snap_d.data    = data;
                snap_d.rd      = rd;
                snap_d.wr      = wr;
                snap_d.cs      = cs;
                active_d       = 1'b1;
                idx_d          = 5'd0;
                state_d        = ST_LOAD;
            end
            ST_LOAD: begin
                tx_data_d = frame_byte;
                if (!tx.tx_busy) state_d = ST_START;
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TO - 1)) begin
                    state_d = ST_NEXT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx.tx_busy) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == 5'(FRAME_LEN - 1)) begin
                    frame_count_d = frame_count_q + 8'd1;
                    active_d      = 1'b0;
                    gap_d         = 8'd0;
                    state_d       = (REPEAT != 0) ? ST_GAP : ST_IDLE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    state_d = sync_q[1] ? ST_CAPTURE : ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, asynchronous abort on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sync_q        <= 3'b000;
            idx_q         <= 5'd0;
            tx_data_q     <= 8'h00;
            active_q      <= 1'b0;
            frame_count_q <= 8'd0;
            timer_q       <= '0;
            gap_q         <= 8'd0;
            snap_q        <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            idx_q         <= idx_d;
            tx_data_q     <= tx_data_d;
            active_q      <= active_d;
            frame_count_q <= frame_count_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            snap_q        <= snap_d;
        end
    end

endmodule
